prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader sitting directly upstream of the JAC1 core's program memory. Accepts a framed byte stream from a UART receiver and assembles 16-bit instructions. Writes each instruction into program memory at consecutive addresses and holds the core in reset until a complete, checksum-verified program has been loaded.

## Interface
- `PC_WIDTH`, default 8: program memory address width. Must be ≥ 8.
- `IRWidth`, default 16: instruction width. Fixed at 2 bytes.
- `TIMEOUT`, default 1000: idle-cycle limit between bytes inside a frame. 0 disables the timeout. Counter is 16 bits.

Ports:
- `clk`  in  1  system clock. Everything is on the rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `rx_valid`  in  1  byte available from the UART receiver.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  loader accepts `rx_data` this cycle.
- `pm_wr_en`  out  1  one-cycle program-memory write strobe.
- `pm_wr_addr`  out  PC_WIDTH  write address.
- `pm_wr_data`  out  IRWidth  instruction, high byte first on the wire.
- `cpu_res_n`  out  1  core reset, active-low. Drives `sys_res_n` of the core.
- `done`  out  1  last load succeeded.
- `err`  out  1  last load failed (checksum or timeout).

## Operation
- A byte is accepted on a rising edge where `rx_valid && rx_ready`.
- Frame format, in order:
  - sync byte 0xA5;
  - length byte N, the number of instructions, where N=0 means 256;
  - N instructions, each as a high byte followed by a low byte;
  - a checksum byte equal to the XOR of all 2N instruction bytes.
- States and transitions:
  - IDLE: bytes other than 0xA5 are consumed and dropped. 0xA5 → LEN.
  - LEN: latch N into a 9-bit remaining count. Clear address to 0 and checksum to 0. → HI.
  - HI: latch the high byte and XOR it into the checksum. → LO.
  - LO: latch the low byte and XOR it into the checksum. → WR.
  - WR: one cycle. `pm_wr_en`=1 with the current address and data; `rx_ready`=0. Address increments and remaining count decrements. If the count reaches 0 → CHK, else → HI.
  - CHK: if the received byte equals the checksum → DONE, else → ERR.
  - DONE: `done`=1 and `cpu_res_n`=1. A received 0xA5 → LEN; other bytes are dropped.
  - ERR: `err`=1 and `cpu_res_n`=0. A received 0xA5 → LEN; other bytes are dropped.
- Entering LEN from any state clears `done` and `err` and drives `cpu_res_n`=0 on the next cycle.
- Timeout: in LEN/HI/LO/CHK, a counter increments each cycle without an accepted byte and clears on every accepted byte. When the counter reaches TIMEOUT → ERR. Memory writes already performed are not undone.
- Address wraps modulo 2^PC_WIDTH. With PC_WIDTH=8 and N=256 the last write goes to 0xFF.
- `rx_ready`=1 in every state except WR.
- `cpu_res_n` stays 0 from reset until the first DONE. The core never runs a partially loaded program.

## Timing
- Reset values:
  - state IDLE;
  - `rx_ready`=1, `pm_wr_en`=0, `pm_wr_addr`=0, `pm_wr_data`=0;
  - `cpu_res_n`=0, `done`=0, `err`=0;
  - checksum, count and timeout counter all 0.
- Asserting `res` mid-load aborts the frame immediately. The loader returns to IDLE with the core held in reset.
- The WR cycle directly follows the cycle in which the low byte is accepted.
- `pm_wr_addr` and `pm_wr_data` are registered and stable during `pm_wr_en`. They hold their values afterwards.
- When the checksum byte is accepted at edge k, `done` (or `err`) and `cpu_res_n` update at edge k+1.
- Back-to-back bytes: the maximum throughput is 2 bytes per 3 cycles during instruction bytes, and 1 byte per cycle elsewhere.
- A timeout fires exactly TIMEOUT cycles after the last accepted byte (or after entering LEN). If a byte is accepted on the same edge the timeout would fire, the byte wins.

## Test plan
- **Normal load.** Send A5 02 12 34 AB CD 40.
  - Writes: 0x1234 to address 0, then 0xABCD to address 1, each with a one-cycle `pm_wr_en`.
  - Then `done`=1, `cpu_res_n`=1, `err`=0.
- **Checksum error.** Send the same frame with checksum 41.
  - The same two writes occur.
  - Then `err`=1, `cpu_res_n`=0, `done`=0.
- **Timeout.** With TIMEOUT=20, send A5 01 12 and then stall.
  - Exactly 20 cycles after 0x12 is accepted, `err`=1.
  - No write occurs.
- **Full memory.** Send A5 00 followed by 256 words, word i = {i, ~i}, and the correct checksum.
  - Addresses 0x00..0xFF are written in order.
  - `done`=1 after the last write.
- **Reload from DONE.** After a successful load, send 0x77, then A5 01 00 01 01.
  - 0x77 is ignored.
  - `cpu_res_n` drops the cycle after LEN is entered.
  - Address 0 is written with 0x0001, then `done`=1.
- **Reset mid-load.** Assert `res` after A5 02 12.
  - All outputs return to their reset values.
  - A subsequent full valid frame loads correctly starting at address 0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (A5, N, N big-endian words, XOR
// checksum), writes the words to consecutive program-memory addresses and
// keeps the core in reset until a whole, checksum-verified program is loaded.
module prog_loader #(
    parameter int PC_WIDTH = 8,
    parameter int IRWidth  = 16,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                res,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                pm_wr_en,
    output logic [PC_WIDTH-1:0] pm_wr_addr,
    output logic [IRWidth-1:0]  pm_wr_data,
    output logic                cpu_res_n,
    output logic                done,
    output logic                err
);

    localparam logic [7:0]  SYNC     = 8'hA5;
    localparam bit          TMO_EN   = (TIMEOUT != 0);
    // Firing on the edge where the counter would reach TIMEOUT.
    localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                timed;
    logic                tmo_hit;
    logic                latch_len;
    logic                take_hi;
    logic                take_lo;
    logic                sum_ok;
    logic [8:0]          remaining;
    logic [7:0]          csum;
    logic [7:0]          hi_byte;
    logic [PC_WIDTH-1:0] addr;
    logic [15:0]         tmo_cnt;

    // A length byte of zero stands for a full 256-word program.
    function automatic logic [8:0] len_decode(input logic [7:0] b);
        return (b == 8'd0) ? 9'd256 : {1'b0, b};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode, handshake and write strobe.
    always_comb begin
        state_nx  = state;
        rx_ready  = (state != S_WR);
        pm_wr_en  = 1'b0;
        latch_len = 1'b0;
        take_hi   = 1'b0;
        take_lo   = 1'b0;
        accept    = rx_valid && rx_ready;
        timed     = (state == S_LEN) || (state == S_HI) ||
                    (state == S_LO)  || (state == S_CHK);
        // An accepted byte on the firing edge wins over the timeout.
        tmo_hit   = TMO_EN && timed && !accept && (tmo_cnt == TMO_LAST);
        sum_ok    = (rx_data == csum);
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && rx_data == SYNC) state_nx = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    latch_len = 1'b1;
                    state_nx  = S_HI;
                end else if (tmo_hit) begin
                    state_nx  = S_ERR;
                end
            end
            S_HI: begin
                if (accept) begin
                    take_hi  = 1'b1;
                    state_nx = S_LO;
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_LO: begin
                if (accept) begin
                    take_lo  = 1'b1;
                    state_nx = S_WR;
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_WR: begin
                pm_wr_en = 1'b1;
                state_nx = (remaining == 9'd1) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (accept)       state_nx = sum_ok ? S_DONE : S_ERR;
                else if (tmo_hit) state_nx = S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Word assembly, running checksum, word count and write address.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            remaining  <= 9'd0;
            csum       <= 8'd0;
            hi_byte    <= 8'd0;
            addr       <= '0;
            pm_wr_addr <= '0;
            pm_wr_data <= '0;
        end else begin
            if (latch_len) begin
                remaining <= len_decode(rx_data);
                csum      <= 8'd0;
                addr      <= '0;
            end
            if (take_hi) begin
                hi_byte <= rx_data;
                csum    <= csum ^ rx_data;
            end
            // Address/data are captured here so they stay put after the strobe.
            if (take_lo) begin
                csum       <= csum ^ rx_data;
                pm_wr_addr <= addr;
                pm_wr_data <= IRWidth'({hi_byte, rx_data});
            end
            if (pm_wr_en) begin
                addr      <= addr + PC_WIDTH'(1);
                remaining <= remaining - 9'd1;
            end
        end
    end

    // Inter-byte idle counter; only runs while a frame is in progress.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tmo_cnt <= 16'd0;
        end else if (!timed || accept || tmo_hit) begin
            tmo_cnt <= 16'd0;
        end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Status lags the state by one cycle; a timeout flags the error on its own edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_res_n <= 1'b0;
        end else if (tmo_hit) begin
            done      <= 1'b0;
            err       <= 1'b1;
            cpu_res_n <= 1'b0;
        end else begin
            case (state)
                S_LEN: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    cpu_res_n <= 1'b0;
                end
                S_DONE: begin
                    done      <= 1'b1;
                    err       <= 1'b0;
                    cpu_res_n <= 1'b1;
                end
                S_ERR: begin
                    done      <= 1'b0;
                    err       <= 1'b1;
                    cpu_res_n <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: spec vectors, a single-word frame table, multi-cycle
// corner cases and randomized frames checked against a frame-level model.
module tb_prog_loader;

    logic        clk;
    logic        res;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        pm_wr_en;
    logic [7:0]  pm_wr_addr;
    logic [15:0] pm_wr_data;
    logic        cpu_res_n;
    logic        done;
    logic        err;

    prog_loader #(.PC_WIDTH(8), .IRWidth(16), .TIMEOUT(20)) dut (
        .clk        (clk),
        .res        (res),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .pm_wr_en   (pm_wr_en),
        .pm_wr_addr (pm_wr_addr),
        .pm_wr_data (pm_wr_data),
        .cpu_res_n  (cpu_res_n),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];
    logic [7:0]  ea_q[$];
    logic [15:0] ed_q[$];
    logic [7:0]  fq[$];
    logic [15:0] words[$];

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] ck;
        logic       exp_done;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Record every memory write; the loader must not take bytes while writing.
    always @(posedge clk) begin
        if (pm_wr_en === 1'b1) begin
            wa_q.push_back(pm_wr_addr);
            wd_q.push_back(pm_wr_data);
            chk("rx_ready_in_wr", {31'd0, rx_ready}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   guard;
        logic acc;
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        do begin
            acc = rx_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 8);
        if (!acc) begin
            n_checks++;
            $display("FAIL send_byte: byte %0h not accepted within 8 cycles", b);
        end
    endtask

    task automatic send_fq(input bit gaps);
        foreach (fq[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b0;
                step($urandom_range(1, 4));
            end
            send_byte(fq[i]);
        end
        rx_valid = 1'b0;
    endtask

    // Frame-level model: words -> byte stream, expected writes, XOR checksum.
    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] x;
        x = 8'd0;
        fq.delete();
        ea_q.delete();
        ed_q.delete();
        fq.push_back(8'hA5);
        fq.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            fq.push_back(words[i][15:8]);
            fq.push_back(words[i][7:0]);
            x ^= words[i][15:8] ^ words[i][7:0];
            ea_q.push_back(8'(i));
            ed_q.push_back(words[i]);
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        fq.push_back(x);
    endtask

    task automatic check_writes(input string name);
        chk({name, "_wr_count"}, wa_q.size(), ea_q.size());
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            chk({name, "_wr_addr"}, {24'd0, wa_q[i]}, {24'd0, ea_q[i]});
            chk({name, "_wr_data"}, {16'd0, wd_q[i]}, {16'd0, ed_q[i]});
        end
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic c);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_err"}, {31'd0, err}, {31'd0, e});
        chk({name, "_cpu_res_n"}, {31'd0, cpu_res_n}, {31'd0, c});
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({name, "_pm_wr_en"}, {31'd0, pm_wr_en}, 32'd0);
        chk({name, "_pm_wr_addr"}, {24'd0, pm_wr_addr}, 32'd0);
        chk({name, "_pm_wr_data"}, {16'd0, pm_wr_data}, 32'd0);
        check_status(name, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic spec_frame(input logic [7:0] ck);
        fq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, ck};
        ea_q = '{8'h00, 8'h01};
        ed_q = '{16'h1234, 16'hABCD};
        send_fq(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h12, 8'h34, 8'h26, 1'b1};
        tbl[1] = '{8'h12, 8'h34, 8'h27, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b1};
        tbl[4] = '{8'hA5, 8'hA5, 8'h00, 1'b1};
        tbl[5] = '{8'h80, 8'h01, 8'h81, 1'b1};
        tbl[6] = '{8'h55, 8'hAA, 8'hFF, 1'b1};
        tbl[7] = '{8'h55, 8'hAA, 8'hFE, 1'b0};

        res      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        res = 1'b0;
        step(1);

        // Normal load from the spec.
        spec_frame(8'h40);
        chk("normal_done_lag", {31'd0, done}, 32'd0);
        step(1);
        check_status("normal", 1'b1, 1'b0, 1'b1);
        check_writes("normal");

        // Checksum error.
        spec_frame(8'h41);
        step(1);
        check_status("badsum", 1'b0, 1'b1, 1'b0);
        check_writes("badsum");

        // Timeout: stall after the first instruction byte.
        fq = '{8'hA5, 8'h01, 8'h12};
        ea_q.delete();
        ed_q.delete();
        send_fq(1'b0);
        step(19);
        chk("timeout_early", {31'd0, err}, 32'd0);
        step(1);
        check_status("timeout", 1'b0, 1'b1, 1'b0);
        check_writes("timeout");

        // Single-word frame table.
        for (int v = 0; v < 8; v++) begin
            fq = '{8'hA5, 8'h01, tbl[v].hi, tbl[v].lo, tbl[v].ck};
            ea_q = '{8'h00};
            ed_q = '{{tbl[v].hi, tbl[v].lo}};
            send_fq(1'b0);
            step(1);
            check_status($sformatf("table%0d", v), tbl[v].exp_done, !tbl[v].exp_done, tbl[v].exp_done);
            check_writes($sformatf("table%0d", v));
        end

        // Full memory: N=0 means 256 words.
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back({8'(i), ~8'(i)});
        build_frame(256, 1'b0);
        send_fq(1'b0);
        step(1);
        check_status("fullmem", 1'b1, 1'b0, 1'b1);
        check_writes("fullmem");

        // Reload from DONE, with a junk byte first.
        send_byte(8'h77);
        rx_valid = 1'b0;
        step(1);
        check_status("reload_junk", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5);
        chk("reload_cpu_still_run", {31'd0, cpu_res_n}, 32'd1);
        send_byte(8'h01);
        chk("reload_cpu_drop", {31'd0, cpu_res_n}, 32'd0);
        chk("reload_done_clear", {31'd0, done}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        rx_valid = 1'b0;
        step(1);
        ea_q = '{8'h00};
        ed_q = '{16'h0001};
        check_status("reload", 1'b1, 1'b0, 1'b1);
        check_writes("reload");

        // Reset mid-load.
        fq = '{8'hA5, 8'h02, 8'h12};
        send_fq(1'b0);
        res = 1'b1;
        #1;
        check_reset_outputs("midreset");
        ea_q.delete();
        ed_q.delete();
        check_writes("midreset");
        step(1);
        res = 1'b0;
        step(1);
        spec_frame(8'h40);
        step(1);
        check_status("after_reset", 1'b1, 1'b0, 1'b1);
        check_writes("after_reset");

        // Randomized frames with junk prefixes and idle gaps.
        for (int f = 0; f < 30; f++) begin
            int  n;
            int  nj;
            bit  corrupt;
            logic [7:0] j;
            n       = $urandom_range(1, 6);
            corrupt = ($urandom_range(0, 3) == 0);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            nj = $urandom_range(0, 2);
            for (int i = 0; i < nj; i++) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j);
            end
            rx_valid = 1'b0;
            build_frame(n, corrupt);
            send_fq(1'b1);
            step(1);
            check_status($sformatf("rand%0d", f), !corrupt, corrupt, !corrupt);
            check_writes($sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
